// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Initiator for the split instruction/data memory port of the multicycle core.
//   It takes one fetch/load/store request at a time over a valid/ready handshake.
//   It drives one memory access and absorbs the memory's one-cycle registered read
//   latency. It returns exactly one response per request. Out-of-range addresses
//   and illegal ops are answered with an error and no memory access.
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   req_valid/ready           request handshake; req_ready is high only in IDLE
//   req_op/addr/wdata         00 fetch, 01 load, 10 store, 11 illegal; word address; store data
//   rsp_valid/ready           response handshake; response is held until accepted
//   rsp_data/err              read word (old word for a store), 0 with err=1 on error
//   mem_addr/wdata/we/iord    memory side; iord 0 = instruction memory, 1 = data memory
//   mem_rdata_im/dm           registered read data from each memory
//   err_count                 saturating count of error responses
module mem_access_sequencer #(
    parameter int INST_DEPTH = 30,
    parameter int DATA_DEPTH = 100,
    parameter int ADDR_W     = $clog2(DATA_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_iord,
    input  logic [31:0]       mem_rdata_im,
    input  logic [31:0]       mem_rdata_dm,
    output logic [7:0]        err_count
);

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    // Limits one bit wider than the address so a depth of 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] IM_LIM = INST_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] DM_LIM = DATA_DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t     state, state_next;
    logic [1:0] op_q;
    logic       req_bad;

    always_comb begin
        req_bad = 1'b0;
        if (req_op == OP_ILL)
            req_bad = 1'b1;
        else if (req_op == OP_FETCH)
            req_bad = ({1'b0, req_addr} >= IM_LIM);
        else
            req_bad = ({1'b0, req_addr} >= DM_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_we     = 1'b0;
        mem_iord   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_bad ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                mem_iord   = (op_q != OP_FETCH);
                // Gated by rst so a reset landing on the ISSUE cycle also cancels the write.
                mem_we     = (op_q == OP_STORE) && !rst;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                mem_iord   = (op_q != OP_FETCH);
                state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // mem_addr/mem_wdata are loaded only on a good accept, so they hold across idle and error traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_FETCH;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end else begin
                            op_q      <= req_op;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                S_WAIT: begin
                    // Read data for the ISSUE-cycle address is valid now; for a store it is the old word.
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= (op_q == OP_FETCH) ? mem_rdata_im : mem_rdata_dm;
                end
                S_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic          mem_iord;
    logic [31:0]   mem_rdata_im = '0;
    logic [31:0]   mem_rdata_dm = '0;
    logic [7:0]    err_count;

    mem_access_sequencer #(.INST_DEPTH(30), .DATA_DEPTH(100)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_iord(mem_iord),
        .mem_rdata_im(mem_rdata_im), .mem_rdata_dm(mem_rdata_dm), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, write-first-read-old on the same edge.
    logic [31:0] im [0:29];
    logic [31:0] dm [0:99];
    always @(posedge clk) begin
        mem_rdata_im <= (mem_addr < 30) ? im[mem_addr] : 32'h0;
        mem_rdata_dm <= (mem_addr < 100) ? dm[mem_addr] : 32'h0;
        if (mem_we && mem_addr < 100) dm[mem_addr] <= mem_wdata;
    end

    int we_cycles = 0;
    int we_bad    = 0;
    always @(negedge clk) begin
        if (mem_we) we_cycles++;
        if (mem_we && !mem_iord) we_bad++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; returns just after the accept edge.
    task automatic req_start(input logic [1:0] op, input logic [AW-1:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int we0;
        logic [31:0] held;
        for (int i = 0; i < 30; i++) im[i] = 32'h1000_0000 + i;
        for (int i = 0; i < 100; i++) dm[i] = 32'h2000_0000 + i;
        im[5] = 32'h2008000A;
        dm[7] = 32'h0000_0011;
        dm[9] = 32'h0000_0055;

        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_rsp_data",  rsp_data,  0);
        check("rst_err_count", err_count, 0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_iord",  mem_iord,  0);
        rst = 1'b0;
        tick();

        // Fetch addr 5
        req_start(2'b00, 7'd5, 32'h0);
        check("fetch_issue_iord",  mem_iord,  0);
        check("fetch_issue_we",    mem_we,    0);
        check("fetch_issue_addr",  mem_addr,  5);
        check("fetch_issue_ready", req_ready, 0);
        tick();
        check("fetch_wait_valid",  rsp_valid, 0);
        tick();
        check("fetch_rsp_valid",   rsp_valid, 1);
        check("fetch_rsp_data",    rsp_data,  32'h2008000A);
        check("fetch_rsp_err",     rsp_err,   0);
        ack();
        check("fetch_done_valid",  rsp_valid, 0);
        check("fetch_done_ready",  req_ready, 1);

        // Store addr 7 returns old word
        we0 = we_cycles;
        req_start(2'b10, 7'd7, 32'hDEADBEEF);
        check("store_issue_we",    mem_we,    1);
        check("store_issue_iord",  mem_iord,  1);
        check("store_issue_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        check("store_wait_we",     mem_we,    0);
        check("store_wait_iord",   mem_iord,  1);
        check("store_wait_addr",   mem_addr,  7);
        tick();
        check("store_rsp_valid",   rsp_valid, 1);
        check("store_rsp_data",    rsp_data,  32'h11);
        ack();
        check("store_idle_iord",   mem_iord,  0);
        check("store_idle_addr",   mem_addr,  7);
        check("store_idle_wdata",  mem_wdata, 32'hDEADBEEF);
        check("store_we_cycles",   we_cycles - we0, 1);
        check("store_dm7",         dm[7],     32'hDEADBEEF);

        // Load addr 7 sees the stored word
        req_start(2'b01, 7'd7, 32'h0);
        wait_rsp(lat);
        check("load_latency",      lat,       2);
        check("load_rsp_data",     rsp_data,  32'hDEADBEEF);
        check("load_rsp_err",      rsp_err,   0);
        ack();

        // Error paths: fetch 30, load 100, illegal op
        we0 = we_cycles;
        req_start(2'b00, 7'd30, 32'h0);
        check("err_fetch_valid", rsp_valid, 1);
        check("err_fetch_err",   rsp_err,   1);
        check("err_fetch_data",  rsp_data,  0);
        ack();
        check("err_fetch_ready", req_ready, 1);
        req_start(2'b01, 7'd100, 32'h0);
        check("err_load_valid",  rsp_valid, 1);
        check("err_load_err",    rsp_err,   1);
        check("err_load_data",   rsp_data,  0);
        ack();
        req_start(2'b11, 7'd3, 32'h0);
        check("err_ill_err",     rsp_err,   1);
        check("err_ill_data",    rsp_data,  0);
        ack();
        check("err_count3",      err_count, 3);
        check("err_no_we",       we_cycles - we0, 0);
        check("err_addr_hold",   mem_addr,  7);

        // Last legal addresses are accepted
        req_start(2'b00, 7'd29, 32'h0);
        wait_rsp(lat);
        check("fetch29_data",    rsp_data,  32'h1000_001D);
        check("fetch29_err",     rsp_err,   0);
        ack();
        req_start(2'b01, 7'd99, 32'h0);
        wait_rsp(lat);
        check("load99_data",     rsp_data,  32'h2000_0063);
        ack();

        // Response stall with ignored request pulses
        req_start(2'b00, 7'd5, 32'h0);
        wait_rsp(lat);
        held = rsp_data;
        check("stall_first_data", held, 32'h2008000A);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0); req_op = 2'b11; req_addr = 7'd1;
            tick();
            check("stall_valid", rsp_valid, 1);
            check("stall_data",  rsp_data,  32'h2008000A);
            check("stall_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        check("stall_err_count", err_count, 3);
        ack();
        check("stall_idle_ready", req_ready, 1);
        check("stall_idle_valid", rsp_valid, 0);

        // Reset during ISSUE of a store
        req_start(2'b10, 7'd9, 32'hCAFEF00D);
        check("rstmid_issue_we", mem_we, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_we",    mem_we,    0);
        check("rstmid_ready", req_ready, 1);
        check("rstmid_cnt",   err_count, 0);
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) lat++;
        end
        check("rstmid_no_rsp", lat, 0);
        check("rstmid_dm9",    dm[9], 32'h55);

        // Saturation
        for (int i = 0; i < 255; i++) begin
            req_start(2'b11, 7'd0, 32'h0);
            ack();
        end
        check("sat_255", err_count, 255);
        for (int i = 0; i < 5; i++) begin
            req_start(2'b11, 7'd0, 32'h0);
            ack();
        end
        check("sat_260", err_count, 255);

        check("we_without_iord", we_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
